// File: rtl/muldiv_pkg.sv
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the iterative multiplier/divider.
//                Holds the operation encodings and the FSM state type.
//                Optional feature macro used by this block: MULDIV_SIGNED_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    // Operation select encodings
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage : muldiv_pkg

`default_nettype wire

// File: rtl/iter_muldiv_if.sv
// ============================================================================
//  Module      : iter_muldiv_if
//  Description : Request/result bundle of the iterative multiplier/divider.
//                master = requester, slave = the arithmetic unit.
//                Optional feature macro used by this block: MULDIV_SIGNED_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iter_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             div_by_zero;

    modport master (
        output start, op, sgn, a, b,
        input  busy, done, lo, hi, div_by_zero
    );

    modport slave (
        input  start, op, sgn, a, b,
        output busy, done, lo, hi, div_by_zero
    );
endinterface : iter_muldiv_if

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ============================================================================
//  Module      : muldiv_signfix
//  Description : Sign conditioning around the unsigned iterative core.
//                Pre path  : operand magnitudes and result-negate flags.
//                Post path : conditional negation of the raw core result.
//                Only instantiated when MULDIV_SIGNED_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    // pre-conditioning (request side)
    input  wire logic             sgn_i,
    input  wire logic             op_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    output logic      [WIDTH-1:0] mag_a_o,
    output logic      [WIDTH-1:0] mag_b_o,
    output logic                  neg_main_o,
    output logic                  neg_rem_o,
    // post-conditioning (result side)
    input  wire logic             fin_op_i,
    input  wire logic             fin_neg_main_i,
    input  wire logic             fin_neg_rem_i,
    input  wire logic [WIDTH-1:0] raw_hi_i,
    input  wire logic [WIDTH-1:0] raw_lo_i,
    output logic      [WIDTH-1:0] hi_o,
    output logic      [WIDTH-1:0] lo_o
);

    logic             w_a_neg;
    logic             w_b_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    // Magnitudes and negate flags; the most-negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    always_comb begin
        w_a_neg    = sgn_i & a_i[WIDTH-1];
        w_b_neg    = sgn_i & b_i[WIDTH-1];
        mag_a_o    = w_a_neg ? (~a_i + 1'b1) : a_i;
        mag_b_o    = w_b_neg ? (~b_i + 1'b1) : b_i;
        neg_main_o = w_a_neg ^ w_b_neg;
        neg_rem_o  = w_a_neg & (op_i == OP_DIV);
    end

    // Product negates as one double-width value; quotient and remainder
    // negate independently.
    always_comb begin
        w_prod     = {raw_hi_i, raw_lo_i};
        w_prod_neg = ~w_prod + 1'b1;
        hi_o       = raw_hi_i;
        lo_o       = raw_lo_i;
        if (fin_op_i == OP_MUL) begin
            if (fin_neg_main_i) begin
                {hi_o, lo_o} = w_prod_neg;
            end
        end else begin
            if (fin_neg_main_i) lo_o = ~raw_lo_i + 1'b1;
            if (fin_neg_rem_i)  hi_o = ~raw_hi_i + 1'b1;
        end
    end

endmodule : muldiv_signfix

`default_nettype wire

// File: rtl/iter_muldiv.sv
// ============================================================================
//  Module      : iter_muldiv
//  Description : Iterative radix-2 multiplier (shift-add) and restoring
//                divider (shift-subtract), WIDTH steps per operation.
//                MULDIV_SIGNED_EN : when defined, sgn=1 selects signed
//                operation via the muldiv_signfix wrapper logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    iter_muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // mul: running high half; div: remainder
    logic [WIDTH-1:0] sh_q, sh_d;       // mul: multiplier/low half; div: dividend/quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;     // mul: multiplicand; div: divisor
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic             w_accept;
    logic             w_div0;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_sh;
    logic [WIDTH-1:0] w_fin_hi;
    logic [WIDTH-1:0] w_fin_lo;

    // A request is taken whenever no operation is running (IDLE or FIN)
    assign w_accept = bus.start & (state_q != ST_RUN);
    assign w_div0   = (bus.op == OP_DIV) && (bus.b == '0);

`ifdef MULDIV_SIGNED_EN
    logic neg_main_q;
    logic neg_rem_q;
    logic w_neg_main;
    logic w_neg_rem;

    muldiv_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .sgn_i          (bus.sgn),
        .op_i           (bus.op),
        .a_i            (bus.a),
        .b_i            (bus.b),
        .mag_a_o        (w_mag_a),
        .mag_b_o        (w_mag_b),
        .neg_main_o     (w_neg_main),
        .neg_rem_o      (w_neg_rem),
        .fin_op_i       (op_q),
        .fin_neg_main_i (neg_main_q),
        .fin_neg_rem_i  (neg_rem_q),
        .raw_hi_i       (w_step_acc),
        .raw_lo_i       (w_step_sh),
        .hi_o           (w_fin_hi),
        .lo_o           (w_fin_lo)
    );

    // Result sign flags captured with the operands
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (w_accept) begin
            neg_main_q <= w_neg_main;
            neg_rem_q  <= w_neg_rem;
        end
    end
`else
    logic w_sgn_unused;

    assign w_sgn_unused = bus.sgn;
    assign w_mag_a      = bus.a;
    assign w_mag_b      = bus.b;
    assign w_fin_hi     = w_step_acc;
    assign w_fin_lo     = w_step_sh;
`endif

    // One radix-2 step of the selected operation
    always_comb begin
        w_mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, dvs_q} : '0);
        w_div_shift = {acc_q, sh_q[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, dvs_q});
        w_div_diff  = w_div_shift[WIDTH-1:0] - dvs_q;
        if (op_q == OP_DIV) begin
            w_step_acc = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            w_step_sh  = {sh_q[WIDTH-2:0], w_div_ge};
        end else begin
            w_step_acc = w_mul_sum[WIDTH:1];
            w_step_sh  = {w_mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    // Next-state, datapath load/step and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (w_accept) begin
                    op_d  = bus.op;
                    cnt_d = '0;
                    acc_d = '0;
                    dbz_d = 1'b0;
                    if (bus.op == OP_DIV) begin
                        sh_d  = w_mag_a;
                        dvs_d = w_mag_b;
                    end else begin
                        sh_d  = w_mag_b;
                        dvs_d = w_mag_a;
                    end
                    if (w_div0) begin
                        // Nothing to iterate: publish the fixed answer now
                        state_d = ST_FIN;
                        hi_d    = bus.a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_FIN) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = w_step_acc;
                sh_d  = w_step_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIN;
                    hi_d    = w_fin_hi;
                    lo_d    = w_fin_lo;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            acc_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == ST_RUN);
    assign bus.done        = (state_q == ST_FIN);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule : iter_muldiv

`default_nettype wire

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be legal for 8..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 op  input  1  0=multiply, 1=divide; sampled on accepted start.
REQ-006 sgn  input  1  1=signed operation; sampled on accepted start (see REQ-025).
REQ-007 a, b  input  WIDTH  multiplicand/dividend, multiplier/divisor; sampled on accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when hi/lo become valid.
REQ-010 lo, hi  output  WIDTH  mul: product low/high half; div: quotient/remainder.
REQ-011 div_by_zero  output  1  set with done when op=1 and b=0; held until next accepted start.

Function
REQ-012 FSM states IDLE, RUN, FIN; reset state IDLE.
REQ-013 IDLE/FIN with start=1: latch operands, clear iteration counter, go RUN (busy=1 next cycle); with start=0 FIN goes IDLE.
REQ-014 RUN: one radix-2 step per cycle; exactly WIDTH steps; after step WIDTH go FIN.
REQ-015 FIN: done=1 for exactly one cycle; hi/lo/div_by_zero updated on the FIN entry edge.
REQ-016 Latency: start accepted at edge N -> done high in cycle N+WIDTH+1; back-to-back start during FIN accepted (throughput one op per WIDTH+1 cycles).
REQ-017 start while busy=1 SHALL be ignored; no operand or op change.
REQ-018 Multiply: shift-add, {hi,lo} = a*b exact 2*WIDTH-bit product.
REQ-019 Divide: restoring shift-subtract, lo = a/b, hi = a%b, truncating.
REQ-020 Divide by zero detected at accept: skip RUN, go FIN next edge; lo = all ones, hi = a, div_by_zero=1.
REQ-021 Iteration counter width $clog2(WIDTH)+1; SHALL not wrap before WIDTH.
REQ-022 hi/lo hold last result until next FIN; unchanged during RUN.

Reset
REQ-023 reset=1 at any edge, including mid-RUN: state IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0; in-flight op discarded.
REQ-024 reset has priority over start in the same cycle.

Configuration
REQ-025 Macro MULDIV_SIGNED_EN defined: sgn=1 runs on magnitudes, then negates: product if a,b signs differ; quotient if signs differ; remainder takes sign of a; one extra cycle NOT added (conditioning combinational at accept/FIN).
REQ-026 MULDIV_SIGNED_EN defined: most-negative / -1 yields lo = most-negative, hi = 0, div_by_zero=0.
REQ-027 MULDIV_SIGNED_EN undefined: sgn ignored, all operations unsigned; sign logic absent.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op encodings (OP_MUL, OP_DIV) and the FSM state type/encodings.
REQ-029 Sign pre/post conditioning SHALL be sub-module muldiv_signfix, instantiated only under MULDIV_SIGNED_EN.

Verification (WIDTH=32)
REQ-030 mul a=0xFFFFFFFF b=0xFFFFFFFF sgn=0 -> done at cycle 33 after accept, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 div a=100 b=7 -> lo=14, hi=2, div_by_zero=0; start pulses during busy ignored, result unchanged.
REQ-032 div a=0x12345678 b=0 -> done 1 cycle after accept, lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1.
REQ-033 With MULDIV_SIGNED_EN: div a=-7 b=2 sgn=1 -> lo=-3 (0xFFFFFFFD), hi=-1; mul a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; div 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-034 reset asserted at RUN step 10 -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows; new start then completes normally.
REQ-035 start held high across FIN -> second op accepted on FIN edge, done pulses every 33 cycles.
